usb_tx_control_fsm: RTL and testbench

- Transmit-side control block of the USB full-speed CDL. Counterpart of the RX control FSM.
- Builds outgoing packets from a packet-type request: SYNC, PID, payload bytes popped from the shared data buffer, CRC16, then EOP.
- Emits an unstuffed, pre-NRZI serial bit stream. The downstream bit-stuffer/NRZI encoder paces it with shift_en, one pulse per transmitted bit and withheld during stuff bits.

---
 rtl/usb_tx_control_fsm.sv | 104 ++++++++++
 tb/tb_usb_tx_control_fsm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_control_fsm.sv
// usb_tx_control_fsm: USB full-speed transmit control, serialising SYNC/PID/payload/CRC16/EOP
module usb_tx_control_fsm #(
    parameter int MAX_PACKET = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    input  logic       shift_en,
    output logic       get_tx_packet_data,
    output logic       tx_bit,
    output logic       tx_eop,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error
);
    typedef enum logic [3:0] {IDLE, SYNC, PID, DATA, CRC_HI, CRC_LO, EOP1, EOP2, IDLE_J} state_t;

    state_t      state, next_state;
    logic [2:0]  bit_cnt, pkt;
    logic [6:0]  byte_cnt;
    logic [7:0]  shreg, pid, cur_byte;
    logic [15:0] crc;
    logic        pop_pend, is_data, req_data, start_ok, start_bad, underflow, byte_end, byte_state;

    assign is_data    = pkt == 3'd1 || pkt == 3'd2;
    assign req_data   = tx_packet == 3'd1 || tx_packet == 3'd2;
    assign start_ok   = state == IDLE && tx_start && tx_packet != 3'd0 && tx_packet[2:1] != 2'b11;
    assign start_bad  = state == IDLE && tx_start && tx_packet[2:1] == 2'b11;
    assign underflow  = state == DATA && pop_pend && buffer_occupancy == 7'd0;
    assign byte_end   = shift_en && bit_cnt == 3'd7;
    assign byte_state = state inside {SYNC, PID, DATA, CRC_HI, CRC_LO};
    assign cur_byte   = pop_pend ? tx_packet_data : shreg;
    assign tx_active  = state != IDLE;
    assign get_tx_packet_data = state == DATA && pop_pend && buffer_occupancy != 7'd0;
    assign pid = pkt == 3'd1 ? 8'hC3 : pkt == 3'd2 ? 8'h4B : pkt == 3'd3 ? 8'hD2 : pkt == 3'd4 ? 8'h5A : 8'h1E;

    // next-state selection and the serial bit driven in the current state
    always_comb begin
        next_state = state;
        tx_bit     = 1'b1;
        tx_eop     = 1'b0;
        case (state)
            IDLE:   next_state = start_ok ? SYNC : IDLE;
            SYNC: begin
                tx_bit = bit_cnt == 3'd7;
                if (byte_end) next_state = PID;
            end
            PID: begin
                tx_bit = pid[bit_cnt];
                if (byte_end) next_state = !is_data ? EOP1 : byte_cnt != 7'd0 ? DATA : CRC_HI;
            end
            DATA: begin
                tx_bit = cur_byte[bit_cnt];
                if (underflow) next_state = EOP1;
                else if (byte_end && byte_cnt == 7'd1) next_state = CRC_HI;
            end
            CRC_HI: begin
                tx_bit = ~crc[{1'b1, ~bit_cnt}];
                if (byte_end) next_state = CRC_LO;
            end
            CRC_LO: begin
                tx_bit = ~crc[{1'b0, ~bit_cnt}];
                if (byte_end) next_state = EOP1;
            end
            EOP1, EOP2: begin
                tx_bit = 1'b0;
                tx_eop = 1'b1;
                if (shift_en) next_state = state == EOP1 ? EOP2 : IDLE_J;
            end
            IDLE_J: if (shift_en) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // state, counters, payload/CRC registers and one-cycle status pulses
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            pkt      <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            crc      <= 16'hFFFF;
            pop_pend <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            state    <= next_state;
            bit_cnt  <= next_state != state ? 3'd0 : (shift_en && byte_state) ? bit_cnt + 3'd1 : bit_cnt;
            pop_pend <= next_state == DATA && (state != DATA || byte_end);
            tx_done  <= state == IDLE_J && shift_en;
            tx_error <= start_bad || underflow;
            if (start_ok) pkt <= tx_packet;
            if (start_ok) byte_cnt <= !req_data ? 7'd0 : buffer_occupancy > 7'(MAX_PACKET) ? 7'(MAX_PACKET) : buffer_occupancy;
            else if (state == DATA && byte_end) byte_cnt <= byte_cnt - 7'd1;
            if (get_tx_packet_data) shreg <= tx_packet_data;
            if (state == IDLE && tx_start) crc <= 16'hFFFF;
            else if (state == DATA && shift_en && !underflow) crc <= {crc[14:0], 1'b0} ^ ((tx_bit ^ crc[15]) ? 16'h8005 : 16'h0000);
        end
    end
endmodule

// File: tb/tb_usb_tx_control_fsm.sv
// tb_usb_tx_control_fsm: directed packet scenarios checked against a bench-built bit stream
module tb_usb_tx_control_fsm;
    logic       clk = 1'b0, n_rst = 1'b0, tx_start = 1'b0, shift_en = 1'b0;
    logic [2:0] tx_packet = '0;
    logic [6:0] buffer_occupancy = '0;
    logic [7:0] tx_packet_data = '0;
    logic       get_tx_packet_data, tx_bit, tx_eop, tx_active, tx_done, tx_error;

    int   tests = 0, fails = 0;
    bit   bits[$], eops[$], xb[$], xe[$];
    int   pop_at[$];
    int   pops, errs, dones, idx, occ_total, m;
    bit   saw_active, force_empty;
    logic [7:0] mem[128];

    usb_tx_control_fsm dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_packet(tx_packet),
        .buffer_occupancy(buffer_occupancy), .tx_packet_data(tx_packet_data), .shift_en(shift_en),
        .get_tx_packet_data(get_tx_packet_data), .tx_bit(tx_bit), .tx_eop(tx_eop),
        .tx_active(tx_active), .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    // expected on-wire stream: SYNC, PID, nb payload bytes from mem, optional inverted CRC16, EOP + J
    task automatic exp_build(input logic [7:0] pid_b, input int nb, input bit with_crc);
        logic [7:0]  s = 8'h80;
        logic [15:0] c = 16'hFFFF;
        logic [7:0]  d;
        bit          b;
        xb.delete(); xe.delete();
        for (int i = 0; i < 8; i++) begin xb.push_back(s[i]); xe.push_back(0); end
        for (int i = 0; i < 8; i++) begin xb.push_back(pid_b[i]); xe.push_back(0); end
        for (int k = 0; k < nb; k++) begin
            d = mem[k];
            for (int i = 0; i < 8; i++) begin
                b = d[i];
                c = {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
                xb.push_back(b); xe.push_back(0);
            end
        end
        if (with_crc) for (int i = 15; i >= 0; i--) begin xb.push_back(~c[i]); xe.push_back(0); end
        xb.push_back(0); xe.push_back(1);
        xb.push_back(0); xe.push_back(1);
        xb.push_back(1); xe.push_back(0);
    endtask

    function automatic int first_diff();
        int n = bits.size() < xb.size() ? bits.size() : xb.size();
        for (int i = 0; i < n; i++) if (bits[i] != xb[i] || eops[i] != xe[i]) return i;
        return bits.size() == xb.size() ? -1 : n;
    endfunction

    // issue one request, pace shift_en every per clocks, model the FWFT buffer, record activity
    task automatic run_pkt(input logic [2:0] ptype, input int occ, input int per, input bit force1, input int budget);
        logic g;
        int   post = 0;
        bits.delete(); eops.delete(); pop_at.delete();
        pops = 0; errs = 0; dones = 0; idx = 0; occ_total = occ; force_empty = 0; saw_active = 0;
        @(posedge clk); #1;
        tx_start = 1; tx_packet = ptype; buffer_occupancy = 7'(occ); tx_packet_data = mem[0]; shift_en = 1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            g = get_tx_packet_data;
            if (tx_active) saw_active = 1;
            if (g) begin pops++; pop_at.push_back(bits.size()); end
            if (shift_en && tx_active) begin bits.push_back(tx_bit); eops.push_back(tx_eop); end
            if (tx_error) errs++;
            if (tx_done) dones++;
            @(posedge clk); #1;
            tx_start = 0;
            if (g) idx++;
            if (force1 && pops >= 1) force_empty = 1;
            buffer_occupancy = force_empty ? 7'd0 : 7'(occ_total - idx);
            tx_packet_data = mem[idx];
            shift_en = ((c + 1) % per) == 0;
            if (dones > 0) post++;
            if (post > 4) break;
        end
        shift_en = 0;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (tx_bit !== 1'b1) begin fails++; $display("FAIL reset_tx_bit got %b want 1", tx_bit); end
        tests++;
        if ({get_tx_packet_data, tx_eop, tx_active, tx_done, tx_error} !== 5'b0) begin
            fails++; $display("FAIL reset_outputs got %b want 00000", {get_tx_packet_data, tx_eop, tx_active, tx_done, tx_error});
        end
        @(negedge clk); n_rst = 1;
    endtask

    task automatic test_ack();
        run_pkt(3'd3, 0, 4, 0, 200);
        exp_build(8'hD2, 0, 0);
        m = first_diff();
        tests++; if (m != -1) begin fails++; $display("FAIL ack_stream diverges at bit %0d (got %0d bits want %0d)", m, bits.size(), xb.size()); end
        tests++; if (bits.size() != 19) begin fails++; $display("FAIL ack_bitcount got %0d want 19", bits.size()); end
        tests++; if (dones != 1) begin fails++; $display("FAIL ack_done got %0d want 1", dones); end
        tests++; if (pops != 0 || errs != 0) begin fails++; $display("FAIL ack_pop_err got pops=%0d errs=%0d want 0/0", pops, errs); end
    endtask

    task automatic test_empty_data();
        run_pkt(3'd1, 0, 3, 0, 300);
        exp_build(8'hC3, 0, 1);
        m = first_diff();
        tests++; if (m != -1) begin fails++; $display("FAIL empty_stream diverges at bit %0d (got %0d bits want %0d)", m, bits.size(), xb.size()); end
        tests++; if (pops != 0 || dones != 1) begin fails++; $display("FAIL empty_pop_done got pops=%0d done=%0d want 0/1", pops, dones); end
    endtask

    task automatic test_data1_two();
        mem[0] = 8'h00; mem[1] = 8'h01;
        run_pkt(3'd2, 2, 1, 0, 300);
        exp_build(8'h4B, 2, 1);
        m = first_diff();
        tests++; if (m != -1) begin fails++; $display("FAIL data1_stream diverges at bit %0d (got %0d bits want %0d)", m, bits.size(), xb.size()); end
        tests++; if (bits.size() != 51) begin fails++; $display("FAIL data1_bitcount got %0d want 51", bits.size()); end
        tests++; if (pops != 2) begin fails++; $display("FAIL data1_pops got %0d want 2", pops); end
        tests++;
        if (pop_at.size() != 2 || pop_at[0] != 16 || pop_at[1] != 24) begin
            fails++; $display("FAIL data1_pop_timing got %0d pops, first at bit %0d want bits 16,24", pop_at.size(), pop_at.size() > 0 ? pop_at[0] : -1);
        end
        tests++; if (dones != 1 || errs != 0) begin fails++; $display("FAIL data1_done_err got done=%0d err=%0d want 1/0", dones, errs); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 128; i++) mem[i] = 8'(i * 37 + 5);
        run_pkt(3'd1, 70, 2, 0, 3000);
        exp_build(8'hC3, 64, 1);
        m = first_diff();
        tests++; if (pops != 64) begin fails++; $display("FAIL sat_pops got %0d want 64", pops); end
        tests++; if (m != -1) begin fails++; $display("FAIL sat_stream diverges at bit %0d (got %0d bits want %0d)", m, bits.size(), xb.size()); end
        tests++; if (pop_at.size() != 64 || pop_at[63] != 520) begin fails++; $display("FAIL sat_last_pop got %0d pops want last at bit 520", pop_at.size()); end
        tests++; if (dones != 1) begin fails++; $display("FAIL sat_done got %0d want 1", dones); end
    endtask

    task automatic test_underflow();
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h0F;
        run_pkt(3'd1, 3, 4, 1, 400);
        exp_build(8'hC3, 1, 0);
        m = first_diff();
        tests++; if (errs != 1) begin fails++; $display("FAIL uflow_error got %0d want 1", errs); end
        tests++; if (pops != 1) begin fails++; $display("FAIL uflow_pops got %0d want 1", pops); end
        tests++; if (m != -1) begin fails++; $display("FAIL uflow_stream diverges at bit %0d (got %0d bits want %0d)", m, bits.size(), xb.size()); end
        tests++; if (dones != 1) begin fails++; $display("FAIL uflow_done got %0d want 1", dones); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
        @(posedge clk); #1;
        tx_start = 1; tx_packet = 3'd1; buffer_occupancy = 7'd5; tx_packet_data = 8'hFF; shift_en = 1;
        @(posedge clk); #1; tx_start = 0;
        repeat (20) @(posedge clk);
        #1;
        tests++; if (tx_active !== 1'b1) begin fails++; $display("FAIL mid_active got %b want 1", tx_active); end
        #2 n_rst = 0;
        #1;
        tests++;
        if (tx_bit !== 1'b1 || tx_active !== 1'b0 || tx_eop !== 1'b0 || get_tx_packet_data !== 1'b0) begin
            fails++; $display("FAIL async_reset got bit=%b act=%b eop=%b get=%b want 1/0/0/0", tx_bit, tx_active, tx_eop, get_tx_packet_data);
        end
        shift_en = 0;
        @(negedge clk); n_rst = 1;
        run_pkt(3'd3, 0, 1, 0, 200);
        exp_build(8'hD2, 0, 0);
        m = first_diff();
        tests++; if (m != -1 || dones != 1) begin fails++; $display("FAIL post_reset_ack diverges at bit %0d done=%0d want -1/1", m, dones); end
    endtask

    task automatic test_invalid();
        run_pkt(3'd7, 0, 1, 0, 10);
        tests++; if (errs != 1) begin fails++; $display("FAIL invalid_error got %0d want 1", errs); end
        tests++; if (saw_active || dones != 0 || bits.size() != 0) begin fails++; $display("FAIL invalid_idle got active=%0d done=%0d bits=%0d want 0/0/0", saw_active, dones, bits.size()); end
        run_pkt(3'd0, 0, 1, 0, 10);
        tests++; if (errs != 0 || saw_active) begin fails++; $display("FAIL none_ignored got err=%0d active=%0d want 0/0", errs, saw_active); end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_empty_data();
        test_data1_two();
        test_saturate();
        test_underflow();
        test_async_reset();
        test_invalid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
